// File: rtl/pipearch_rd_reorder.sv
// -----------------------------------------------------------------------------
// pipearch_rd_reorder
//
// Read-response reorder buffer for the read DMA stage. Each read request sent
// to CCI-P is given a tag (placed in mdata) taken from a circular tail pointer.
// Read responses come back out of order and are written into a data RAM by tag.
// Lines are released strictly in request order, through a 2-entry output FIFO,
// on a valid/ready stream to the DMA read consumer. The slot count doubles as
// the credit that throttles request issue.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   alloc_valid     issuer wants a tag for a new read request
//   alloc_ready     a free slot exists (derived from registered count only)
//   alloc_tag       tag for the request; equals the tail pointer
//   rsp_valid       read response this cycle (no backpressure)
//   rsp_tag         tag returned in the response mdata
//   rsp_data        response cache line
//   out_valid       in-order line available
//   out_ready       consumer accepts line
//   out_data        in-order line (don't-care while out_valid=0)
//   outstanding     slots allocated and not yet delivered (0..DEPTH)
//   error           sticky: response to an unallocated or already-filled slot
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Once out_valid is high it stays high with out_data stable until the
// transfer. alloc_ready does not depend on alloc_valid. rsp_valid is a
// single-cycle strobe with no ready.
// -----------------------------------------------------------------------------
module pipearch_rd_reorder #(
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  rsp_valid,
    input  logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH:0]    outstanding,
    output logic                  error
);

    localparam int DEPTH = 1 << TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] DEPTH_C = (TAG_WIDTH + 1)'(DEPTH);

    logic [TAG_WIDTH-1:0]  tail_q, tail_d;
    logic [TAG_WIDTH-1:0]  head_q, head_d;
    logic [TAG_WIDTH:0]    count_q, count_d;
    logic [DEPTH-1:0]      filled_q, filled_d;
    logic                  error_q, error_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic                  fifo_wr_q, fifo_rd_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mem_q [2];

    logic                  alloc_fire;
    logic                  pop;
    logic                  issue;
    logic [TAG_WIDTH:0]    pending;
    logic [TAG_WIDTH-1:0]  rsp_offset;
    logic                  rsp_ok;

    assign alloc_ready = (count_q < DEPTH_C);
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign out_valid   = (fifo_cnt_q != 2'd0);
    assign out_data    = fifo_mem_q[fifo_rd_q];
    assign pop         = out_valid && out_ready;

    assign outstanding = count_q;
    assign error       = error_q;

    // The RAM read register is the FIFO slot itself, so a read issued this
    // cycle is a FIFO entry next cycle. A pop in the same cycle frees a slot,
    // which keeps one line per cycle flowing with out_ready held high.
    assign issue = filled_q[head_q] && ((fifo_cnt_q != 2'd2) || pop);

    // Slots head..tail-1 are allocated but not yet read out of the RAM; their
    // number is count minus the lines already sitting in the FIFO.
    assign pending    = count_q - {{(TAG_WIDTH - 1){1'b0}}, fifo_cnt_q};
    assign rsp_offset = rsp_tag - head_q;
    assign rsp_ok     = rsp_valid && ({1'b0, rsp_offset} < pending) && !filled_q[rsp_tag];

    always_comb begin
        tail_d     = tail_q;
        head_d     = head_q;
        count_d    = count_q;
        filled_d   = filled_q;
        error_d    = error_q;
        fifo_cnt_d = fifo_cnt_q;

        if (alloc_fire) begin
            tail_d = tail_q + TAG_WIDTH'(1);
        end

        // Delivery, not RAM read, releases the slot so it cannot be
        // reallocated while its line still waits in the FIFO.
        unique case ({alloc_fire, pop})
            2'b10:   count_d = count_q + (TAG_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (TAG_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase

        // issue needs filled=1 and a write needs filled=0, so they never
        // touch the same slot in one cycle.
        if (issue) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + TAG_WIDTH'(1);
        end
        if (rsp_ok) begin
            filled_d[rsp_tag] = 1'b1;
        end
        if (rsp_valid && !rsp_ok) begin
            error_d = 1'b1;
        end

        unique case ({issue, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tail_q     <= '0;
            head_q     <= '0;
            count_q    <= '0;
            filled_q   <= '0;
            error_q    <= 1'b0;
            fifo_cnt_q <= 2'd0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
        end else begin
            tail_q     <= tail_d;
            head_q     <= head_d;
            count_q    <= count_d;
            filled_q   <= filled_d;
            error_q    <= error_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (issue) begin
                fifo_wr_q <= ~fifo_wr_q;
            end
            if (pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
        end
    end

    // Data storage carries no reset: validity is tracked by filled_q and
    // fifo_cnt_q, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (rsp_ok && !reset) begin
            mem[rsp_tag] <= rsp_data;
        end
        if (issue && !reset) begin
            fifo_mem_q[fifo_wr_q] <= mem[head_q];
        end
    end

endmodule

// File: doc/pipearch_rd_reorder.md
Name: pipearch_rd_reorder

Overview:
- Sits between the CCI-P c0 read-response path and the DMA read consumer inside the read DMA stage.
- CCI-P returns read responses out of order. This block hands out in-order tags for mdata, stores returning lines by tag, and releases them strictly in request order on a valid/ready stream to the accelerator datapath (glm_top DMA_read data side).
- It also provides the credit that throttles read-request issue.

Parameters:
DATA_WIDTH, 512, width of one cache line of read data
TAG_WIDTH, 7, tag/slot index width; DEPTH = 2**TAG_WIDTH slots (128)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
alloc_valid  in  1  request issuer wants a tag (one per read request sent to CCI-P)
alloc_ready  out  1  a free slot exists; allocation happens on alloc_valid && alloc_ready
alloc_tag  out  TAG_WIDTH  tag for this request, placed in mdata; equals tail pointer
rsp_valid  in  1  CCI-P read response (c0 RspValid, ReadLine) this cycle
rsp_tag  in  TAG_WIDTH  tag returned in response mdata
rsp_data  in  DATA_WIDTH  response line
out_valid  out  1  in-order line available
out_ready  in  1  consumer accepts line
out_data  out  DATA_WIDTH  in-order line
outstanding  out  TAG_WIDTH+1  slots allocated and not yet delivered (0..DEPTH)
error  out  1  sticky: response to unallocated or already-filled slot

Behaviour:
- State: tail pointer (alloc), head pointer (drain), per-slot filled bits, slot-allocated count, 1R1W data RAM (read latency 1 cycle), 2-entry output FIFO.
- Reset:
  - Pointers, count and filled bits are cleared; FIFO is emptied.
  - Outputs after reset: alloc_ready=1, alloc_tag=0, out_valid=0, outstanding=0, error=0. out_data is don't-care while out_valid=0.
  - Reset mid-operation drops all stored data and in-flight reads.
  - Responses arriving after reset for pre-reset tags hit unallocated slots and set error.
- Allocation:
  - alloc_ready = (count < DEPTH).
  - On alloc_valid && alloc_ready: tail increments modulo DEPTH and count increments.
  - alloc_tag is combinational from tail.
- Response write:
  - On rsp_valid: write rsp_data to RAM[rsp_tag] and set filled[rsp_tag].
  - If the slot is not allocated (outside the circular window head..tail-1 given count) or is already filled: no write, error<=1 (sticky until reset).
  - rsp_valid has no backpressure; the block accepts one response every cycle.
- Drain:
  - A RAM read of slot head is issued when filled[head]=1 and (fifo_count + read_in_flight) < 2.
  - On issue: clear filled[head], head increments modulo DEPTH. Next cycle, the read data enters the output FIFO.
  - count decrements when a line leaves the FIFO (out_valid && out_ready), not at RAM read. outstanding = count.
  - out_valid = FIFO non-empty; out_data = FIFO head entry.
- Latency: response written in cycle t to the head slot with FIFO empty -> out_valid in cycle t+2.
- Throughput: sustains 1 line/cycle in and out with out_ready held high.
- Simultaneous events:
  - alloc and delivery in the same cycle leave count unchanged.
  - A response to slot head in the same cycle as a drain check is seen next cycle; filled is read as a registered value.
  - A response write and a RAM read to different slots in the same cycle are legal.
  - Wrap-around: a slot can be reallocated only after its line has left the FIFO, because count covers FIFO occupancy.
- Full: at count=DEPTH, alloc_ready=0 until a delivery. Allocation in the cycle of that delivery is allowed only on the following cycle; alloc_ready is computed from registered count.

Test Plan:
- In-order: allocate tags 0..7, respond with tags 0..7 one per cycle, out_ready=1 -> out_data sequence 0..7; first out_valid 2 cycles after rsp of tag 0; outstanding returns to 0.
- Reverse order: allocate 0..3, respond 3,2,1,0 -> no out_valid until tag 0 arrives; then lines 0,1,2,3 on consecutive cycles.
- Full/wrap: allocate 128 -> alloc_ready=0, outstanding=128. Respond to all, deliver 1 -> alloc_ready=1 next cycle and alloc_tag=0. Continue allocating to 300 total with random response order -> data always in order, no error.
- Backpressure: out_ready toggled randomly with 1 line/cycle responses -> no loss or duplication; FIFO never exceeds 2; count matches scoreboard.
- Error: respond to an unallocated tag 5 with count=0 -> error=1, no out_valid. Respond twice to an allocated tag 2 -> error=1, only the first data is delivered.
- Reset mid-operation: 10 outstanding with 4 filled, assert reset 1 cycle -> outstanding=0, out_valid=0, alloc_tag=0. A late response with tag 3 -> error=1.
